muldiv_sequencer: RTL and testbench

Iterative multiply/divide sequencer for the EX stage, implementing the RV32M operations selected by Funct3 when the decoder flags an M-extension R-type instruction (opcode 0110011, Funct7 0000001). It shares the EX stage with the single-cycle ALU. While an operation is in flight it holds the pipeline via Stall, runs a radix-2 shift-add or shift-subtract loop for DATA_WIDTH cycles, and presents a one-cycle Done with the final Result.

---
 rtl/muldiv_pkg.sv | 37 +++
 rtl/muldiv_step.sv | 33 +++
 rtl/muldiv_sequencer.sv | 143 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide sequencer.
// Also holds the Funct3 decode helpers used by the accept logic.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic a_is_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// Accumulator is {hi, lo}: multiplier/partial product or remainder/quotient.
module muldiv_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      div_mode_i,
    input  logic [2*DATA_WIDTH-1:0]   acc_i,
    input  logic [DATA_WIDTH-1:0]     operand_i,
    output logic [2*DATA_WIDTH-1:0]   acc_o
);
    localparam int W = DATA_WIDTH;

    logic [W:0] add_sum;
    logic [W:0] partial;
    logic [W:0] trial;

    always_comb begin
        add_sum = {1'b0, acc_i[2*W-1:W]} + (acc_i[0] ? {1'b0, operand_i} : '0);
        // Remainder shifted left with the next dividend bit; top bit of trial is the borrow.
        partial = acc_i[2*W-1:W-1];
        trial   = partial - {1'b0, operand_i};
        if (div_mode_i) begin
            if (trial[W]) begin
                acc_o = {partial[W-1:0], acc_i[W-2:0], 1'b0};
            end else begin
                acc_o = {trial[W-1:0], acc_i[W-2:0], 1'b1};
            end
        end else begin
            acc_o = {add_sum, acc_i[W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// EX-stage RV32M sequencer: holds the pipeline via Stall for DATA_WIDTH iterations,
// then pulses Done with the sign-corrected Result. Divide-by-zero and overflow finish immediately.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    input  logic                  flush,
    output logic                  Busy,
    output logic                  Stall,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] Result
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);
    localparam logic [W-1:0]  MOST_NEG  = {1'b1, {(W-1){1'b0}}};

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      f3_q;
    logic [2*W-1:0]  acc_q;
    logic [W-1:0]    opnd_q;
    logic            neg_main_q;
    logic            neg_rem_q;
    logic [W-1:0]    result_q;
    logic            done_q;

    logic [2*W-1:0]  acc_d;
    logic            sign_a;
    logic            sign_b;
    logic [W-1:0]    mag_a;
    logic [W-1:0]    mag_b;
    logic            div_zero;
    logic            div_ovf;
    logic [W-1:0]    special_res;

    always_comb begin
        sign_a      = a_is_signed(Funct3) && SrcA[W-1];
        sign_b      = b_is_signed(Funct3) && SrcB[W-1];
        mag_a       = sign_a ? -SrcA : SrcA;
        mag_b       = sign_b ? -SrcB : SrcB;
        div_zero    = is_div(Funct3) && (SrcB == '0);
        div_ovf     = ((Funct3 == F3_DIV) || (Funct3 == F3_REM)) &&
                      (SrcA == MOST_NEG) && (SrcB == '1);
        special_res = '0;
        if (div_zero) begin
            special_res = Funct3[1] ? SrcA : '1;
        end else if (div_ovf) begin
            special_res = Funct3[1] ? '0 : MOST_NEG;
        end
    end

    muldiv_step #(.DATA_WIDTH(W)) u_step (
        .div_mode_i (is_div(f3_q)),
        .acc_i      (acc_q),
        .operand_i  (opnd_q),
        .acc_o      (acc_d)
    );

    // Sign fixup on magnitude results; neg_main covers product and quotient alike.
    function automatic logic [W-1:0] fixup(input logic [2:0] f3, input logic [2*W-1:0] acc,
                                           input logic neg_main, input logic neg_rem);
        logic [2*W-1:0] prod;
        logic [W-1:0]   quo;
        logic [W-1:0]   rem;
        prod = neg_main ? -acc : acc;
        quo  = neg_main ? -acc[W-1:0] : acc[W-1:0];
        rem  = neg_rem ? -acc[2*W-1:W] : acc[2*W-1:W];
        case (f3)
            F3_MUL:                      return prod[W-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: return prod[2*W-1:W];
            F3_DIV, F3_DIVU:             return quo;
            default:                     return rem;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            f3_q       <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            done_q     <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        f3_q       <= Funct3;
                        cnt_q      <= '0;
                        neg_main_q <= sign_a ^ sign_b;
                        neg_rem_q  <= sign_a;
                        if (is_div(Funct3)) begin
                            acc_q  <= {{W{1'b0}}, mag_a};
                            opnd_q <= mag_b;
                        end else begin
                            acc_q  <= {{W{1'b0}}, mag_b};
                            opnd_q <= mag_a;
                        end
                        if (div_zero || div_ovf) begin
                            result_q <= special_res;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_ITER) begin
                        result_q <= fixup(f3_q, acc_d, neg_main_q, neg_rem_q);
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Busy   = (state_q != IDLE);
    assign Stall  = (start && (state_q == IDLE) && !flush) || (state_q == BUSY);
    assign Done   = done_q;
    assign Result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench: stimulus pushes expected result and Done cycle into a scoreboard,
// a negedge monitor pops and compares whenever Done is seen.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  Funct3;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        flush;
    logic        Busy;
    logic        Stall;
    logic        Done;
    logic [31:0] Result;

    typedef struct {
        string       name;
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    muldiv_sequencer #(.DATA_WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .Funct3 (Funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .flush  (flush),
        .Busy   (Busy),
        .Stall  (Stall),
        .Done   (Done),
        .Result (Result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset && Done) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: Done=1 Result=%h at cycle %0d, required no Done", Result, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                if (Result !== mon_e.res || cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL %s: Result=%h at cycle %0d, required %h at cycle %0d",
                             mon_e.name, Result, cyc, mon_e.res, mon_e.cyc);
                end else begin
                    $display("ok   %s: Result=%h at cycle %0d", mon_e.name, Result, cyc);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that ends the DONE cycle.
    task automatic do_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input bit special,
                         input bit release_start);
        bit seen = 0;
        Funct3 = f3;
        SrcA   = a;
        SrcB   = b;
        start  = 1'b1;
        sb_q.push_back('{nm, exp, cyc + (special ? 1 : 33)});
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk({nm, "_stall"}, 32'(Stall), 32'(!Done));
            if (Done) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            #1;
            if (i == 3) begin
                SrcA = ~a;
                SrcB = a ^ b;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: Done=0 after 40 cycles, required Done", nm);
        end
        @(posedge clk);
        #1;
        if (release_start) start = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        Funct3 = 3'b000;
        SrcA   = '0;
        SrcB   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy",   32'(Busy),  32'd0);
        chk("reset_stall",  32'(Stall), 32'd0);
        chk("reset_done",   32'(Done),  32'd0);
        chk("reset_result", Result,     32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        do_op("mul_neg",    F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0, 1);
        do_op("mulhu_ff",   F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 1);
        do_op("mulh_ff",    F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0, 1);
        do_op("mulhsu",     F3_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 0, 1);
        do_op("div_neg",    F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 1);
        do_op("rem_neg",    F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0, 1);
        do_op("divu",       F3_DIVU,   32'd100,      32'd7,        32'd14,       0, 1);
        do_op("remu",       F3_REMU,   32'd100,      32'd7,        32'd2,        0, 1);

        // Flush in cycle 10 of a MUL: no Done may follow.
        Funct3 = F3_MUL;
        SrcA   = 32'd3;
        SrcB   = 32'd5;
        start  = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("flush_busy",  32'(Busy),  32'd0);
        chk("flush_stall", 32'(Stall), 32'd0);
        chk("flush_keeps_result", Result, 32'd2);
        repeat (40) @(posedge clk);
        #1;

        // Reset in cycle 20 of a MUL clears Result.
        start = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("midreset_result", Result,     32'd0);
        chk("midreset_busy",   32'(Busy),  32'd0);
        repeat (40) @(posedge clk);
        #1;
        do_op("divu_after_reset", F3_DIVU, 32'd9, 32'd3, 32'd3, 0, 1);

        do_op("divu_by0",   F3_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1, 1);
        do_op("rem_by0",    F3_REM,    32'd5,        32'd0,        32'd5,        1, 1);
        do_op("div_ovf",    F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1);
        do_op("rem_ovf",    F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 1);

        // Back-to-back with start held high across the first Done.
        do_op("b2b_mul_a",  F3_MUL,    32'd6,        32'd7,        32'd42,       0, 0);
        do_op("b2b_mul_b",  F3_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        0, 1);

        repeat (3) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

endmodule
